// File: rtl/riscv_single_cycle_if.sv
// Observation bundle of the single-cycle core: decoded controls plus the
// fetch/execute/memory buses of the instruction retiring this cycle.
interface riscv_single_cycle_if;
   logic        reg_we;
   logic        mem_we;
   logic [2:0]  imm_src;
   logic [3:0]  alu_ctrl;
   logic        alu_src;
   logic [1:0]  res_src;
   logic [1:0]  pc_src;
   logic [31:0] instr;
   logic [31:0] alu_out;
   logic [31:0] mem_rd_data;
   logic [31:0] mem_wd_data;
   logic [31:0] pc;

   modport master (output reg_we, mem_we, imm_src, alu_ctrl, alu_src, res_src, pc_src,
                          instr, alu_out, mem_rd_data, mem_wd_data, pc);
   modport slave  (input  reg_we, mem_we, imm_src, alu_ctrl, alu_src, res_src, pc_src,
                          instr, alu_out, mem_rd_data, mem_wd_data, pc);
endinterface

// File: rtl/riscv_single_cycle.sv
// Single-cycle RV32I subset core with internal instruction and data memories.
// One instruction is fetched, decoded, executed and retired per clk.

// Word-addressed memory: async read, write on rising edge; out-of-range reads 0.
module word_mem #(parameter int WORDS = 64) (
   input  logic        clk,
   input  logic        we,
   input  logic [31:2] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd
);
   localparam int AW = $clog2(WORDS);
   logic [31:0] _mem [0:WORDS-1];
   logic        in_range;

   assign in_range = {2'b00, addr} < 32'(WORDS);
   assign rd       = in_range ? _mem[addr[AW+1:2]] : '0;

   // store one word; writes outside the array are dropped
   always_ff @(posedge clk) begin
      if (we && in_range) _mem[addr[AW+1:2]] <= wd;
   end
endmodule

// Instruction memory: read-only from the core, contents are backdoor loaded.
module riscv_imem #(parameter int WORDS = 64) (
   input  logic        clk,
   input  logic [31:2] addr,
   output logic [31:0] instr
);
   word_mem #(.WORDS(WORDS)) _mem (.clk(clk), .we(1'b0), .addr(addr), .wd(32'd0), .rd(instr));
endmodule

// Register file: two async read ports, one write port; x0 is hardwired to 0.
module riscv_rf (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] _reg [0:31];

   assign rd1 = (ra1 == 5'd0) ? '0 : _reg[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : _reg[ra2];

   // writeback; x0 never updated
   always_ff @(posedge clk) begin
      if (we && wa != 5'd0) _reg[wa] <= wd;
   end
endmodule

// Main decoder plus ALU decoder.
module riscv_ctrl (
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic       f7b5,
   input  logic       zero,
   output logic       reg_we,
   output logic       mem_we,
   output logic [2:0] imm_src,
   output logic [3:0] alu_ctrl,
   output logic       alu_src,
   output logic [1:0] res_src,
   output logic [1:0] pc_src,
   output logic       a_zero
);
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                          SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;

   // funct7[5] selects SUB only for R-type; for shifts it selects SRA in both formats
   function automatic logic [3:0] alu_dec(input logic [2:0] f, input logic b5, input logic rtype);
      case (f)
         3'd0:    alu_dec = (rtype && b5) ? SUB : ADD;
         3'd1:    alu_dec = SLL;
         3'd2:    alu_dec = SLT;
         3'd3:    alu_dec = SLTU;
         3'd4:    alu_dec = XOR;
         3'd5:    alu_dec = b5 ? SRA : SRL;
         3'd6:    alu_dec = OR;
         default: alu_dec = AND;
      endcase
   endfunction

   // decode opcode; unknown opcodes fall through to a harmless pc+4 no-op
   always_comb begin
      reg_we = 1'b0; mem_we = 1'b0; imm_src = 3'd0; alu_ctrl = ADD;
      alu_src = 1'b0; res_src = 2'd0; pc_src = 2'd0; a_zero = 1'b0;
      case (op)
         7'b0110011: begin reg_we = 1'b1; alu_ctrl = alu_dec(f3, f7b5, 1'b1); end
         7'b0010011: begin reg_we = 1'b1; alu_src = 1'b1; alu_ctrl = alu_dec(f3, f7b5, 1'b0); end
         7'b0000011: begin reg_we = 1'b1; alu_src = 1'b1; res_src = 2'd1; end
         7'b0100011: begin mem_we = 1'b1; alu_src = 1'b1; imm_src = 3'd1; end
         7'b1100011: begin
            imm_src  = 3'd2;
            alu_ctrl = SUB;
            if ((f3 == 3'd0 && zero) || (f3 == 3'd1 && !zero)) pc_src = 2'd1;
         end
         7'b1101111: begin reg_we = 1'b1; imm_src = 3'd3; res_src = 2'd2; pc_src = 2'd1; end
         7'b1100111: begin reg_we = 1'b1; alu_src = 1'b1; res_src = 2'd2; pc_src = 2'd2; end
         7'b0110111: begin reg_we = 1'b1; alu_src = 1'b1; imm_src = 3'd4; a_zero = 1'b1; end
         default: ;
      endcase
   end
endmodule

// Datapath: pc register, immediate generator, ALU, register file, result/next-pc muxes.
module riscv_dp (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:7] ins,
   input  logic        reg_we,
   input  logic [2:0]  imm_src,
   input  logic [3:0]  alu_ctrl,
   input  logic        alu_src,
   input  logic [1:0]  res_src,
   input  logic [1:0]  pc_src,
   input  logic        a_zero,
   input  logic [31:0] mem_rd_data,
   output logic [31:0] pc,
   output logic [31:0] alu_out,
   output logic [31:0] wd_data,
   output logic        zero
);
   logic [31:0] pc_q = '0;
   logic [31:0] rs1, rs2, imm, a, b, res, pc_next;

   // architectural state is frozen while rst is high
   riscv_rf rf (.clk(clk), .we(reg_we & ~rst), .ra1(ins[19:15]), .ra2(ins[24:20]),
                .wa(ins[11:7]), .wd(res), .rd1(rs1), .rd2(rs2));

   assign pc      = pc_q;
   assign wd_data = rs2;
   assign a       = a_zero ? '0 : rs1;
   assign b       = alu_src ? imm : rs2;
   assign zero    = (alu_out == '0);

   // sign-extended immediate for the selected format
   always_comb begin
      imm = '0;
      case (imm_src)
         3'd0: imm = {{20{ins[31]}}, ins[31:20]};
         3'd1: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         3'd2: imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         3'd3: imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         3'd4: imm = {ins[31:12], 12'b0};
         default: imm = '0;
      endcase
   end

   // ALU; shift amounts use the low five bits of b
   always_comb begin
      alu_out = '0;
      case (alu_ctrl)
         4'd0: alu_out = a + b;
         4'd1: alu_out = a - b;
         4'd2: alu_out = a & b;
         4'd3: alu_out = a | b;
         4'd4: alu_out = a ^ b;
         4'd5: alu_out = {31'b0, $signed(a) < $signed(b)};
         4'd6: alu_out = {31'b0, a < b};
         4'd7: alu_out = a << b[4:0];
         4'd8: alu_out = a >> b[4:0];
         4'd9: alu_out = $unsigned($signed(a) >>> b[4:0]);
         default: alu_out = '0;
      endcase
   end

   // writeback source and next pc
   always_comb begin
      res = alu_out;
      case (res_src)
         2'd1:    res = mem_rd_data;
         2'd2:    res = pc_q + 32'd4;
         default: res = alu_out;
      endcase
      pc_next = pc_q + 32'd4;
      case (pc_src)
         2'd1:    pc_next = pc_q + imm;
         2'd2:    pc_next = {alu_out[31:1], 1'b0};
         default: pc_next = pc_q + 32'd4;
      endcase
   end

   // pc register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_next;
   end
endmodule

module riscv_single_cycle #(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input logic                   clk,
   input logic                   rst,
   riscv_single_cycle_if.master  obs
);
   logic [31:0] instr, pc, alu_out, rd_data, wd_data;
   logic        reg_we, mem_we, alu_src, zero, a_zero;
   logic [2:0]  imm_src;
   logic [3:0]  alu_ctrl;
   logic [1:0]  res_src, pc_src;

   riscv_imem #(.WORDS(IMEM_WORDS)) instr_mem (.clk(clk), .addr(pc[31:2]), .instr(instr));

   riscv_ctrl ctrl (.op(instr[6:0]), .f3(instr[14:12]), .f7b5(instr[30]), .zero(zero),
                    .reg_we(reg_we), .mem_we(mem_we), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
                    .alu_src(alu_src), .res_src(res_src), .pc_src(pc_src), .a_zero(a_zero));

   riscv_dp dp (.clk(clk), .rst(rst), .ins(instr[31:7]), .reg_we(reg_we), .imm_src(imm_src),
                .alu_ctrl(alu_ctrl), .alu_src(alu_src), .res_src(res_src), .pc_src(pc_src),
                .a_zero(a_zero), .mem_rd_data(rd_data), .pc(pc), .alu_out(alu_out),
                .wd_data(wd_data), .zero(zero));

   word_mem #(.WORDS(DMEM_WORDS)) data_mem (.clk(clk), .we(mem_we & ~rst), .addr(alu_out[31:2]),
                                             .wd(wd_data), .rd(rd_data));

   assign obs.reg_we      = reg_we;
   assign obs.mem_we      = mem_we;
   assign obs.imm_src     = imm_src;
   assign obs.alu_ctrl    = alu_ctrl;
   assign obs.alu_src     = alu_src;
   assign obs.res_src     = res_src;
   assign obs.pc_src      = pc_src;
   assign obs.instr       = instr;
   assign obs.alu_out     = alu_out;
   assign obs.mem_rd_data = rd_data;
   assign obs.mem_wd_data = wd_data;
   assign obs.pc          = pc;
endmodule

// File: tb/tb_riscv_single_cycle.sv
// Bench for riscv_single_cycle: directed checks of the documented scenarios,
// then random programs run in lockstep with an instruction-level model.
module tb_riscv_single_cycle;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] m_reg  [32];
   logic [31:0] m_imem [64];
   logic [31:0] m_dmem [64];
   logic [31:0] m_pc;

   riscv_single_cycle_if obs ();
   riscv_single_cycle #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (.clk(clk), .rst(rst), .obs(obs));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // instruction encoders
   function automatic logic [31:0] enc_r(input logic b5, input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
      return {1'b0, b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic push_state();
      for (int i = 0; i < 64; i++) dut.instr_mem._mem._mem[i] = m_imem[i];
      for (int i = 0; i < 64; i++) dut.data_mem._mem[i] = m_dmem[i];
      for (int i = 0; i < 32; i++) dut.dp.rf._reg[i] = m_reg[i];
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = 32'd0;
   endtask

   function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic b5, input logic rtype,
                                         input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return (rtype && b5) ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return b5 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   // execute one instruction in the model, compare the DUT's view of it, clock both
   task automatic model_cycle();
      logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, res, npc, addr;
      logic        we, mwe, ck_alu;
      logic [1:0]  psrc;
      ins   = (m_pc[31:8] == 24'd0) ? m_imem[m_pc[7:2]] : 32'd0;
      a     = m_reg[ins[19:15]];
      b     = m_reg[ins[24:20]];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      npc = m_pc + 32'd4; we = 1'b0; mwe = 1'b0; psrc = 2'd0; ck_alu = 1'b0; res = 32'd0; addr = 32'd0;
      case (ins[6:0])
         7'b0110011: begin we = 1'b1; ck_alu = 1'b1; res = m_alu(ins[14:12], ins[30], 1'b1, a, b); end
         7'b0010011: begin we = 1'b1; ck_alu = 1'b1; res = m_alu(ins[14:12], ins[30], 1'b0, a, imm_i); end
         7'b0000011: begin
            we = 1'b1; ck_alu = 1'b1; addr = a + imm_i; res = m_dmem[addr[7:2]];
            chk("lw_rdata", obs.mem_rd_data, res);
         end
         7'b0100011: begin
            mwe = 1'b1; ck_alu = 1'b1; addr = a + imm_s;
            chk("sw_wdata", obs.mem_wd_data, b);
         end
         7'b1100011: begin
            if ((ins[14:12] == 3'd0 && a == b) || (ins[14:12] == 3'd1 && a != b)) begin
               npc = m_pc + imm_b; psrc = 2'd1;
            end
         end
         7'b1101111: begin we = 1'b1; res = m_pc + 32'd4; npc = m_pc + imm_j; psrc = 2'd1; end
         7'b1100111: begin we = 1'b1; res = m_pc + 32'd4; npc = (a + imm_i) & ~32'd1; psrc = 2'd2; end
         7'b0110111: begin we = 1'b1; ck_alu = 1'b1; res = {ins[31:12], 12'b0}; end
         default: ;
      endcase
      if (ck_alu) chk("alu_out", obs.alu_out, (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) ? addr : res);
      chk("pc", obs.pc, m_pc);
      chk("instr", obs.instr, ins);
      chk("reg_we", 32'(obs.reg_we), 32'(we));
      chk("mem_we", 32'(obs.mem_we), 32'(mwe));
      chk("pc_src", 32'(obs.pc_src), 32'(psrc));
      tick();
      if (we && ins[11:7] != 5'd0) m_reg[ins[11:7]] = res;
      if (mwe) m_dmem[addr[7:2]] = b;
      m_pc = npc;
   endtask

   // random program: forward-only control flow inside words 0..60, then loop to 0
   task automatic gen_program();
      int k, r;
      logic [2:0] f3;
      logic [11:0] imm;
      logic [4:0] rs1, rs2;
      for (int i = 0; i < 64; i++) m_imem[i] = 32'd0;
      for (int i = 0; i < 60; i++) begin
         r   = $urandom_range(0, 9);
         f3  = 3'($urandom_range(0, 7));
         rs1 = 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         k   = $urandom_range(1, 4);
         if (i + k > 60) k = 60 - i;
         case (r)
            0: m_imem[i] = enc_r((f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0,
                                 f3, 5'($urandom_range(0, 31)), rs1, rs2);
            1, 2: begin
               imm = 12'($urandom);
               if (f3 == 3'd1) imm = {7'b0, imm[4:0]};
               if (f3 == 3'd5) imm = {1'b0, imm[10], 5'b0, imm[4:0]};
               m_imem[i] = enc_i(7'b0010011, imm, f3, 5'($urandom_range(0, 31)), rs1);
            end
            3: m_imem[i] = {20'($urandom), 5'($urandom_range(0, 31)), 7'b0110111};
            4: m_imem[i] = enc_s(12'(4 * $urandom_range(0, 63)), rs2, 5'd0);
            5: m_imem[i] = enc_i(7'b0000011, 12'(4 * $urandom_range(0, 63)), 3'b010,
                                 5'($urandom_range(0, 31)), 5'd0);
            6: m_imem[i] = enc_b(13'(4 * k), {2'b00, 1'($urandom_range(0, 1))}, rs1,
                                 ($urandom_range(0, 1) == 1) ? rs1 : rs2);
            7: m_imem[i] = enc_j(21'(4 * k), 5'($urandom_range(0, 31)));
            8: m_imem[i] = enc_i(7'b1100111, 12'(4 * (i + k)), 3'd0, 5'($urandom_range(0, 31)), 5'd0);
            default: m_imem[i] = {25'($urandom), 7'b1111111};
         endcase
      end
      m_imem[60] = enc_j(21'(-240), 5'd0);
   endtask

   initial begin
      // reset and jalr ping-pong
      for (int i = 0; i < 64; i++) begin m_imem[i] = 32'd0; m_dmem[i] = 32'd0; end
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_reg[3] = 32'd8; m_reg[4] = 32'd4;
      m_imem[0] = 32'h004180e7;
      m_imem[3] = 32'hffc200e7;
      push_state();
      do_reset();
      chk("rst_pc", obs.pc, 32'd0);
      chk("rst_x1", dut.dp.rf._reg[1], 32'd0);
      chk("jalr_pc_src", 32'(obs.pc_src), 32'd2);
      chk("jalr_res_src", 32'(obs.res_src), 32'd2);
      tick();
      chk("jalr1_pc", obs.pc, 32'd12);
      chk("jalr1_x1", dut.dp.rf._reg[1], 32'd4);
      tick();
      chk("jalr2_pc", obs.pc, 32'd0);
      chk("jalr2_x1", dut.dp.rf._reg[1], 32'd16);

      // directed ALU / memory / branch / jal program
      rst = 1'b1;
      for (int i = 0; i < 64; i++) dut.instr_mem._mem._mem[i] = 32'd0;
      dut.instr_mem._mem._mem[0] = enc_i(7'b0010011, 12'hfff, 3'd0, 5'd1, 5'd0);
      dut.instr_mem._mem._mem[1] = enc_r(1'b0, 3'd0, 5'd2, 5'd1, 5'd1);
      dut.instr_mem._mem._mem[2] = enc_i(7'b0010011, 12'd5, 3'd0, 5'd0, 5'd0);
      dut.instr_mem._mem._mem[3] = enc_s(12'd8, 5'd2, 5'd0);
      dut.instr_mem._mem._mem[4] = enc_i(7'b0000011, 12'd8, 3'b010, 5'd5, 5'd0);
      dut.instr_mem._mem._mem[5] = enc_b(13'd8, 3'd0, 5'd1, 5'd1);
      dut.instr_mem._mem._mem[6] = enc_i(7'b0010011, 12'd1, 3'd0, 5'd6, 5'd0);
      dut.instr_mem._mem._mem[7] = enc_b(13'd8, 3'd0, 5'd1, 5'd2);
      dut.instr_mem._mem._mem[8] = enc_j(21'(-8), 5'd1);
      tick();
      rst = 1'b0;
      tick();
      chk("addi_x1", dut.dp.rf._reg[1], 32'hffffffff);
      tick();
      chk("add_x2", dut.dp.rf._reg[2], 32'hfffffffe);
      tick();
      chk("x0_kept", dut.dp.rf._reg[0], 32'd0);
      chk("sw_mem_we", 32'(obs.mem_we), 32'd1);
      chk("sw_addr", obs.alu_out, 32'd8);
      tick();
      chk("lw_addr", obs.alu_out, 32'd8);
      chk("lw_rdata", obs.mem_rd_data, 32'hfffffffe);
      chk("lw_mem_we", 32'(obs.mem_we), 32'd0);
      tick();
      chk("lw_x5", dut.dp.rf._reg[5], 32'hfffffffe);
      chk("beq_t_src", 32'(obs.pc_src), 32'd1);
      tick();
      chk("beq_t_pc", obs.pc, 32'd28);
      chk("beq_n_src", 32'(obs.pc_src), 32'd0);
      tick();
      chk("beq_n_pc", obs.pc, 32'd32);
      tick();
      chk("jal_pc", obs.pc, 32'd24);
      chk("jal_ra", dut.dp.rf._reg[1], 32'd36);
      tick();
      chk("addi_x6", dut.dp.rf._reg[6], 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_pc", obs.pc, 32'd0);
      chk("midrst_x6", dut.dp.rf._reg[6], 32'd1);
      chk("midrst_x1", dut.dp.rf._reg[1], 32'd36);

      // fetch past the end of instruction memory reads 0
      for (int i = 0; i < 64; i++) dut.instr_mem._mem._mem[i] = 32'd0;
      dut.instr_mem._mem._mem[0] = enc_i(7'b1100111, 12'h100, 3'd0, 5'd0, 5'd0);
      do_reset();
      tick();
      chk("oob_pc", obs.pc, 32'd256);
      chk("oob_instr", obs.instr, 32'd0);
      chk("oob_reg_we", 32'(obs.reg_we), 32'd0);
      tick();
      chk("oob_next_pc", obs.pc, 32'd260);

      // random programs against the model
      for (int p = 0; p < 4; p++) begin
         gen_program();
         for (int i = 0; i < 64; i++) m_dmem[i] = $urandom;
         m_reg[0] = 32'd0;
         for (int i = 1; i < 32; i++) m_reg[i] = $urandom;
         push_state();
         do_reset();
         for (int c = 0; c < 200; c++) model_cycle();
         for (int i = 1; i < 32; i++) chk($sformatf("p%0d_x%0d", p, i), dut.dp.rf._reg[i], m_reg[i]);
         for (int i = 0; i < 64; i++) chk($sformatf("p%0d_dmem%0d", p, i), dut.data_mem._mem[i], m_dmem[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
